// File: rtl/rmst_arbiter.sv
// rmst_arbiter
//   Round-robin owner selection for one shared read master. Each requester
//   posts a 1-cycle req pulse with an address/size; the arbiter latches it,
//   hands the master one transfer at a time, and steers the returned stream
//   beats to the current owner. A per-requester abort (end_conv flush) lets
//   an in-flight transfer drain into the bit bucket without stalling.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   req/req_addr/req_size per-requester request pulse and its address/size slice
//   abort                per-requester flush
//   done                 1-cycle completion pulse to the owner
//   grant                one-hot current owner (0 when idle)
//   busy                 FSM not idle
//   m_start/m_addr/m_size command to the read master
//   m_done               read master completion pulse
//   s_tdata/s_valid/s_ready stream from the read master
//   o_tdata/o_valid/o_ready stream fan-out to the requesters
//   dbg_state            FSM state (0 idle, 1 issue, 2 xfer, 3 done)
//
// Handshake: a beat moves on a channel in any cycle where valid and ready are
// both high; valid never waits for ready, and once raised, valid and data are
// held until that transfer cycle. This block is combinational on the stream
// path, so it passes s_valid straight to the owner and its ready straight back.

module rmst_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_size,
  input  logic [NUM_REQ-1:0]            abort,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          m_start,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [ADDR_WIDTH-1:0]         m_size,
  input  logic                          m_done,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         o_tdata,
  output logic [NUM_REQ-1:0]            o_valid,
  input  logic [NUM_REQ-1:0]            o_ready,
  output logic [1:0]                    dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic [NUM_REQ-1:0]                   pending_q, pending_d;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   size_q, size_d;
  logic [NUM_REQ-1:0]                   grant_q, grant_d;
  logic [IDX_W-1:0]                     last_q, last_d;
  logic [ADDR_WIDTH-1:0]                m_addr_q, m_addr_d;
  logic [ADDR_WIDTH-1:0]                m_size_q, m_size_d;
  logic                                 drop_q, drop_d;

  logic                                 win_found;
  logic [IDX_W-1:0]                     win_idx;

  // Round-robin search starting just after the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (int'(last_q) + k) % NUM_REQ;
      if (!win_found && pending_q[c]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(c);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    size_d    = size_q;
    grant_d   = grant_q;
    last_d    = last_q;
    m_addr_d  = m_addr_q;
    m_size_d  = m_size_q;
    drop_d    = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d            = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          m_addr_d           = addr_q[win_idx];
          m_size_d           = size_q[win_idx];
          last_d             = win_idx;
          pending_d[win_idx] = 1'b0;
          // A zero-byte request never touches the master.
          state_d            = (size_q[win_idx] == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (|(abort & grant_q)) drop_d = 1'b1;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        if (|(abort & grant_q)) drop_d = 1'b1;
        if (m_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        grant_d = '0;
        drop_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the winner clear so a fresh pulse in the grant cycle
    // (including the owner re-requesting) is kept for a later round.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (abort[i]) begin
        pending_d[i] = 1'b0;
      end else if (req[i]) begin
        pending_d[i] = 1'b1;
        addr_d[i]    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        size_d[i]    = req_size[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      m_addr_q  <= '0;
      m_size_q  <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      m_addr_q  <= m_addr_d;
      m_size_q  <= m_size_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    grant     = grant_q;
    busy      = (state_q != ST_IDLE);
    m_start   = (state_q == ST_ISSUE);
    m_addr    = m_addr_q;
    m_size    = m_size_q;
    done      = (state_q == ST_DONE && !drop_q) ? grant_q : '0;
    o_tdata   = s_tdata;
    s_ready   = 1'b0;
    o_valid   = '0;
    dbg_state = state_q;
    if (state_q == ST_XFER) begin
      // A flushed transfer is drained at full rate regardless of the owner.
      s_ready = drop_q ? 1'b1 : |(o_ready & grant_q);
      o_valid = (s_valid && !drop_q) ? grant_q : '0;
    end
  end

endmodule

// File: tb/tb_rmst_arbiter.sv
module tb_rmst_arbiter;
  localparam int NR = 2;
  localparam int DW = 512;
  localparam int AW = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*AW-1:0]  req_size;
  logic [NR-1:0]     abort;
  logic [NR-1:0]     done;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              m_start;
  logic [AW-1:0]     m_addr;
  logic [AW-1:0]     m_size;
  logic              m_done;
  logic [DW-1:0]     s_tdata;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     o_tdata;
  logic [NR-1:0]     o_valid;
  logic [NR-1:0]     o_ready;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  rmst_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_size(req_size),
    .abort(abort), .done(done), .grant(grant), .busy(busy), .m_start(m_start),
    .m_addr(m_addr), .m_size(m_size), .m_done(m_done), .s_tdata(s_tdata),
    .s_valid(s_valid), .s_ready(s_ready), .o_tdata(o_tdata), .o_valid(o_valid),
    .o_ready(o_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; req_addr = '0; req_size = '0; abort = '0;
    m_done = 1'b0; s_tdata = '0; s_valid = 1'b0; o_ready = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // drivers
  task automatic set_req(input int idx, input logic [AW-1:0] addr, input logic [AW-1:0] size);
    req[idx] = 1'b1;
    req_addr[idx*AW +: AW] = addr;
    req_size[idx*AW +: AW] = size;
  endtask

  function automatic logic [DW-1:0] beat_data(input int i);
    return {16{32'hC0DE0000 ^ 32'(i)}};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_addr = '0; req_size = '0; abort = '0;
    m_done = 1'b0; s_tdata = '0; s_valid = 1'b1; o_ready = '1;
    #3;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 2'b00 || m_start !== 1'b0) begin failures++; $display("FAIL reset_pulses done=%b m_start=%b exp=00/0", done, m_start); end
    checks++; if (m_addr !== 64'd0 || m_size !== 64'd0) begin failures++; $display("FAIL reset_cmd addr=%h size=%h exp=0/0", m_addr, m_size); end
    checks++; if (s_ready !== 1'b0 || o_valid !== 2'b00) begin failures++; $display("FAIL reset_stream s_ready=%b o_valid=%b exp=0/00", s_ready, o_valid); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    apply_reset();
  endtask

  task automatic test_single();
    int bad = 0;
    set_req(0, 64'h1000, 64'd4096);
    tick(); req = '0;
    tick();
    checks++; if (m_start !== 1'b1 || grant !== 2'b01) begin failures++; $display("FAIL single_issue m_start=%b grant=%b exp=1/01", m_start, grant); end
    checks++; if (m_addr !== 64'h1000 || m_size !== 64'd4096) begin failures++; $display("FAIL single_cmd addr=%h size=%0d exp=1000/4096", m_addr, m_size); end
    tick();
    checks++; if (m_start !== 1'b0 || dbg_state !== 2'd2) begin failures++; $display("FAIL single_xfer m_start=%b state=%0d exp=0/2", m_start, dbg_state); end
    o_ready = 2'b11;
    for (int b = 0; b < 64; b++) begin
      s_valid = 1'b1; s_tdata = beat_data(b);
      #1;
      if (o_valid !== 2'b01 || s_ready !== 1'b1 || o_tdata !== beat_data(b)) bad++;
      tick();
    end
    s_valid = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL single_beats bad=%0d exp=0", bad); end
    m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (done !== 2'b01 || busy !== 1'b1) begin failures++; $display("FAIL single_done done=%b busy=%b exp=01/1", done, busy); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 2'b00 || grant !== 2'b00) begin failures++; $display("FAIL single_idle busy=%b done=%b grant=%b exp=0/00/00", busy, done, grant); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    set_req(0, 64'h1000, 64'd64); set_req(1, 64'h2000, 64'd128);
    tick(); req = '0;
    tick();
    checks++; if (grant !== 2'b01 || m_addr !== 64'h1000) begin failures++; $display("FAIL simul_first grant=%b addr=%h exp=01/1000", grant, m_addr); end
    tick();
    // both re-request while requester 0 owns the master
    set_req(0, 64'h3000, 64'd32); set_req(1, 64'h2200, 64'd96);
    tick(); req = '0;
    m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (done !== 2'b01 || m_start !== 1'b0) begin failures++; $display("FAIL simul_done0 done=%b m_start=%b exp=01/0", done, m_start); end
    tick();
    checks++; if (m_start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL simul_gap m_start=%b busy=%b exp=0/0", m_start, busy); end
    tick();
    checks++; if (m_start !== 1'b1 || grant !== 2'b10) begin failures++; $display("FAIL simul_second m_start=%b grant=%b exp=1/10", m_start, grant); end
    checks++; if (m_addr !== 64'h2200 || m_size !== 64'd96) begin failures++; $display("FAIL simul_cmd1 addr=%h size=%0d exp=2200/96", m_addr, m_size); end
    tick(); m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (done !== 2'b10) begin failures++; $display("FAIL simul_done1 got=%b exp=10", done); end
    tick(); tick();
    checks++; if (grant !== 2'b01 || m_addr !== 64'h3000 || m_start !== 1'b1) begin failures++; $display("FAIL simul_third grant=%b addr=%h m_start=%b exp=01/3000/1", grant, m_addr, m_start); end
    tick(); m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (done !== 2'b01) begin failures++; $display("FAIL simul_done2 got=%b exp=01", done); end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL simul_drained busy=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    int beat = 0, sr_bad = 0, data_bad = 0;
    logic tog;
    for (int i = 0; i < 16; i++) exp_q.push_back(beat_data(100 + i));
    set_req(1, 64'h4000, 64'd1024);
    tick(); req = '0;
    tick();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", grant); end
    tick();
    for (int c = 0; c < 64 && beat < 16; c++) begin
      tog = c[0];
      o_ready = {tog, 1'b1};
      s_valid = 1'b1; s_tdata = beat_data(100 + beat);
      #1;
      if (s_ready !== tog || o_valid !== 2'b10) sr_bad++;
      if (o_valid[1] && o_ready[1]) begin
        if (exp_q.size() == 0) data_bad++;
        else begin
          if (o_tdata !== exp_q[0]) data_bad++;
          void'(exp_q.pop_front());
        end
      end
      if (s_valid && s_ready) beat++;
      tick();
    end
    s_valid = 1'b0; o_ready = 2'b11;
    checks++; if (sr_bad !== 0) begin failures++; $display("FAIL bp_ready_mirror bad=%0d exp=0", sr_bad); end
    checks++; if (data_bad !== 0 || exp_q.size() !== 0) begin failures++; $display("FAIL bp_order bad=%0d left=%0d exp=0/0", data_bad, exp_q.size()); end
    exp_q.delete();
    m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (done !== 2'b10) begin failures++; $display("FAIL bp_done got=%b exp=10", done); end
    tick();
  endtask

  task automatic test_abort();
    int bad = 0;
    set_req(0, 64'h1000, 64'd4096);
    tick(); req = '0;
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL abort_grant got=%b exp=01", grant); end
    tick();
    o_ready = 2'b11;
    for (int b = 0; b < 10; b++) begin
      s_valid = 1'b1; s_tdata = beat_data(b);
      tick();
    end
    s_valid = 1'b0;
    abort = 2'b01;
    set_req(1, 64'h5000, 64'd64);
    tick(); abort = '0; req = '0;
    o_ready = 2'b00;
    for (int b = 10; b < 64; b++) begin
      s_valid = 1'b1; s_tdata = beat_data(b);
      #1;
      if (s_ready !== 1'b1 || o_valid !== 2'b00) bad++;
      tick();
    end
    s_valid = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL abort_drain bad=%0d exp=0", bad); end
    m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (done !== 2'b00 || dbg_state !== 2'd3) begin failures++; $display("FAIL abort_no_done done=%b state=%0d exp=00/3", done, dbg_state); end
    tick(); tick();
    checks++; if (grant !== 2'b10 || m_start !== 1'b1 || m_addr !== 64'h5000) begin failures++; $display("FAIL abort_next grant=%b m_start=%b addr=%h exp=10/1/5000", grant, m_start, m_addr); end
    tick();
    s_valid = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0 || o_valid !== 2'b10) begin failures++; $display("FAIL abort_drop_cleared s_ready=%b o_valid=%b exp=0/10", s_ready, o_valid); end
    s_valid = 1'b0;
    m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (done !== 2'b10) begin failures++; $display("FAIL abort_done1 got=%b exp=10", done); end
    tick();
  endtask

  task automatic test_zero_size();
    set_req(1, 64'h6000, 64'd0);
    tick(); req = '0;
    checks++; if (m_start !== 1'b0) begin failures++; $display("FAIL zero_pending m_start=%b exp=0", m_start); end
    tick();
    checks++; if (dbg_state !== 2'd3 || done !== 2'b10 || m_start !== 1'b0) begin failures++; $display("FAIL zero_done state=%0d done=%b m_start=%b exp=3/10/0", dbg_state, done, m_start); end
    checks++; if (m_addr !== 64'h6000 || m_size !== 64'd0) begin failures++; $display("FAIL zero_cmd addr=%h size=%0d exp=6000/0", m_addr, m_size); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 2'b00) begin failures++; $display("FAIL zero_idle busy=%b done=%b exp=0/00", busy, done); end
    // abort beats req in the same cycle
    set_req(0, 64'h7000, 64'd64); abort = 2'b01;
    tick(); req = '0; abort = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_wins busy=%b exp=0", busy); end
    // abort of a non-owner clears its pending request, owner unaffected
    set_req(1, 64'h8000, 64'd64);
    tick(); req = '0;
    tick(); tick();
    set_req(0, 64'h9000, 64'd64);
    tick(); req = '0; abort = 2'b01;
    tick(); abort = '0;
    m_done = 1'b1; tick(); m_done = 1'b0;
    abort = 2'b10;
    #1;
    checks++; if (done !== 2'b10) begin failures++; $display("FAIL nonowner_abort_done got=%b exp=10", done); end
    tick(); abort = '0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nonowner_pending_cleared busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    set_req(0, 64'hA000, 64'd64);
    tick(); req = '0;
    tick(); tick();
    set_req(1, 64'hB000, 64'd64);
    o_ready = 2'b11; s_valid = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_pre s_ready=%b exp=1", s_ready); end
    tick(); req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || busy !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL rst_mid grant=%b busy=%b state=%0d exp=00/0/0", grant, busy, dbg_state); end
    checks++; if (s_ready !== 1'b0 || o_valid !== 2'b00 || m_addr !== 64'd0) begin failures++; $display("FAIL rst_mid_stream s_ready=%b o_valid=%b addr=%h exp=0/00/0", s_ready, o_valid, m_addr); end
    s_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_pending_cleared busy=%b exp=0", busy); end
    set_req(1, 64'hC000, 64'd128);
    tick(); req = '0;
    tick();
    checks++; if (grant !== 2'b10 || m_start !== 1'b1 || m_addr !== 64'hC000) begin failures++; $display("FAIL rst_after grant=%b m_start=%b addr=%h exp=10/1/C000", grant, m_start, m_addr); end
    tick(); m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (done !== 2'b10) begin failures++; $display("FAIL rst_after_done got=%b exp=10", done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_abort();
    test_zero_size();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
